// File: rtl/adc_capture_pkg.sv
// Shared types and width helpers for the serial ADC capture front end.
// Build option: ADC_CAPTURE_TEST_PATTERN_EN swaps captured data for a ramp.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } state_t;

  localparam int DEF_DATA_IN_WIDTH = 12;
  localparam int DEF_SAMPLING_RATE = 512;

  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_serial_capture_if.sv
// ADC pins plus the sample strobe/data bundle feeding the averager.
// master = capture block, slave = ADC model / downstream consumer.
interface adc_serial_capture_if #(
  parameter int DATA_OUT_WIDTH = 21
);
  logic                      i_enable;
  logic                      i_sdata;
  logic                      o_cs_n;
  logic                      o_sclk;
  logic                      o_valid;
  logic [DATA_OUT_WIDTH-1:0] o_data;
  logic                      o_overrun;

  modport master (
    input  i_enable,
    input  i_sdata,
    output o_cs_n,
    output o_sclk,
    output o_valid,
    output o_data,
    output o_overrun
  );

  modport slave (
    output i_enable,
    output i_sdata,
    input  o_cs_n,
    input  o_sclk,
    input  o_valid,
    input  o_data,
    input  o_overrun
  );
endinterface

// File: rtl/sclk_gen.sv
// SCLK generator: half-period and bit counters, rise strobe, last-bit flag.
// A start pulse launches FRAME_BITS low/high SCLK periods; SCLK idles high.
module sclk_gen
  import adc_capture_pkg::*;
#(
  parameter int SCLK_HALF  = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic sclk,
  output logic rise,
  output logic last
);

  localparam int HW = cw(SCLK_HALF);
  localparam int BW = cw(FRAME_BITS);

  logic          active;
  logic          high;
  logic [HW-1:0] hcnt;
  logic [BW-1:0] bcnt;
  logic          half_end;

  assign half_end = active && (hcnt == HW'(SCLK_HALF - 1));
  assign rise     = half_end && !high;
  assign last     = half_end && high &&
                    (bcnt == BW'(FRAME_BITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      high   <= 1'b0;
      hcnt   <= '0;
      bcnt   <= '0;
      sclk   <= 1'b1;
    end else if (start) begin
      active <= 1'b1;
      high   <= 1'b0;
      hcnt   <= '0;
      bcnt   <= '0;
      sclk   <= 1'b0;
    end else if (last) begin
      active <= 1'b0;
      high   <= 1'b0;
      hcnt   <= '0;
      sclk   <= 1'b1;
    end else if (half_end) begin
      hcnt <= '0;
      high <= !high;
      sclk <= !high;
      if (high) bcnt <= bcnt + 1'b1;
    end else if (active) begin
      hcnt <= hcnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_serial_capture.sv
// Serial ADC capture: periodic CS_N/SCLK frames, sample strobe to averager.
// Build option: ADC_CAPTURE_TEST_PATTERN_EN outputs a ramp instead of i_sdata.
module adc_serial_capture
  import adc_capture_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
  parameter int SAMPLING_RATE  = DEF_SAMPLING_RATE,
  parameter int DATA_OUT_WIDTH = DATA_IN_WIDTH + $clog2(SAMPLING_RATE),
  parameter int FRAME_BITS     = 16,
  parameter int LEAD_BITS      = 4,
  parameter int SCLK_HALF      = 4,
  parameter int CONV_PERIOD    = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  adc_serial_capture_if.master bus
);

  localparam int PW = cw(CONV_PERIOD);
  localparam int SW = cw(SCLK_HALF);

  if (LEAD_BITS + DATA_IN_WIDTH > FRAME_BITS) begin : g_cfg_check
    $error("LEAD_BITS + DATA_IN_WIDTH exceeds FRAME_BITS");
  end

  state_t          state;
  logic [PW-1:0]   pcnt;
  logic [SW-1:0]   scnt;
  logic            tick;
  logic            start;
  logic            rise;
  logic            last;

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
  logic [DATA_IN_WIDTH-1:0] ramp;
`else
  logic                     sd_q;
  logic [DATA_IN_WIDTH-1:0] shreg;
`endif

  assign tick  = bus.i_enable &&
                 (pcnt == PW'(CONV_PERIOD - 1));
  assign start = (state == SETUP) &&
                 (scnt == SW'(SCLK_HALF - 1));

  sclk_gen #(
    .SCLK_HALF  (SCLK_HALF),
    .FRAME_BITS (FRAME_BITS)
  ) u_sclk (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sclk  (bus.o_sclk),
    .rise  (rise),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (!bus.i_enable || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

`ifndef ADC_CAPTURE_TEST_PATTERN_EN
  // Only the trailing DATA_IN_WIDTH bits survive; lead bits fall off the top.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sd_q  <= 1'b0;
      shreg <= '0;
    end else begin
      sd_q <= bus.i_sdata;
      if (rise) shreg <= DATA_IN_WIDTH'({shreg, sd_q});
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      scnt          <= '0;
      bus.o_cs_n    <= 1'b1;
      bus.o_valid   <= 1'b0;
      bus.o_data    <= '0;
      bus.o_overrun <= 1'b0;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
      ramp          <= '0;
`endif
    end else begin
      bus.o_valid   <= 1'b0;
      bus.o_overrun <= tick && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (tick) begin
            state      <= SETUP;
            scnt       <= '0;
            bus.o_cs_n <= 1'b0;
          end
        end
        SETUP: begin
          if (start) state <= SHIFT;
          else       scnt  <= scnt + 1'b1;
        end
        SHIFT: begin
          if (last) begin
            state       <= DONE;
            bus.o_cs_n  <= 1'b1;
            bus.o_valid <= 1'b1;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
            bus.o_data  <= DATA_OUT_WIDTH'(ramp);
            ramp        <= ramp + 1'b1;
`else
            bus.o_data  <= DATA_OUT_WIDTH'(shreg);
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_capture.sv
// Bench for adc_serial_capture: ADC model, vector table, scoreboard queues.
// Covers capture data, frame timing, enable drop, mid-frame reset, overrun.
module tb_adc_serial_capture;

  localparam int DOW = 21;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_serial_capture_if #(.DATA_OUT_WIDTH(DOW)) b0 ();
  adc_serial_capture_if #(.DATA_OUT_WIDTH(DOW)) b1 ();

  adc_serial_capture #(.CONV_PERIOD(200)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  adc_serial_capture #(.CONV_PERIOD(100)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  typedef struct {
    logic [15:0]    frame;
    logic [DOW-1:0] exp;
  } vec_t;

  vec_t vecs [8];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] adc_word;
  int bi0 = 0;
  int bi1 = 0;

  logic [DOW-1:0] q0 [$];
  logic [DOW-1:0] q1 [$];

  int nval0 = 0, lastv0 = 0, gap0 = 0;
  int nval1 = 0, lastv1 = 0, gap1 = 0, ov1 = 0;
  bit pv0 = 0, pv1 = 0, ps0 = 1;
  int cslo0 = 0, rises0 = 0, cswid0 = 0, nrise0 = 0;
  int sclkbad = 0;
  logic [11:0] ramp0 = '0, ramp1 = '0;

  always @(posedge clk) cyc++;

  // ADC model: MSB out at CS_N fall, next bit after each SCLK rise.
  always @(negedge b0.o_cs_n) bi0 = 0;
  always @(posedge b0.o_sclk) if (!b0.o_cs_n) bi0 = bi0 + 1;
  always @(negedge b1.o_cs_n) bi1 = 0;
  always @(posedge b1.o_sclk) if (!b1.o_cs_n) bi1 = bi1 + 1;
  assign b0.i_sdata = (bi0 < 16) ? adc_word[15-bi0] : 1'b0;
  assign b1.i_sdata = (bi1 < 16) ? adc_word[15-bi1] : 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [DOW-1:0] e;
    if (!rst) begin
      ramp0 = '0;
      ramp1 = '0;
    end
    if (rst && b0.o_valid) begin
      check("v0_back_to_back", 32'(pv0), 32'd0);
      if (q0.size() == 0) begin
        check("v0_unexpected", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
        e = DOW'(ramp0);
        ramp0 = ramp0 + 1'b1;
`endif
        check("v0_data", 32'(b0.o_data), 32'(e));
      end
      gap0 = cyc - lastv0;
      lastv0 = cyc;
      nval0++;
    end
    pv0 = b0.o_valid;
    if (!b0.o_cs_n) begin
      cslo0++;
      if (!ps0 && b0.o_sclk) rises0++;
    end else begin
      if (cslo0 != 0) begin
        cswid0 = cslo0;
        nrise0 = rises0;
      end
      cslo0 = 0;
      rises0 = 0;
      if (!b0.o_sclk) sclkbad++;
    end
    ps0 = b0.o_sclk;
  end

  always @(negedge clk) begin
    logic [DOW-1:0] e;
    if (rst && b1.o_overrun) ov1++;
    if (rst && b1.o_valid) begin
      check("v1_back_to_back", 32'(pv1), 32'd0);
      if (q1.size() == 0) begin
        check("v1_unexpected", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
        e = DOW'(ramp1);
        ramp1 = ramp1 + 1'b1;
`endif
        check("v1_data", 32'(b1.o_data), 32'(e));
      end
      if (nval1 > 0) check("v1_overrun_per_frame", 32'(ov1), 32'd1);
      ov1 = 0;
      gap1 = cyc - lastv1;
      lastv1 = cyc;
      nval1++;
    end
    pv1 = b1.o_valid;
  end

  task automatic wait_v(input int dut, input int target,
                        input int budget);
    int n = 0;
    bit got = 0;
    while (!got && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      got = ((dut == 0) ? nval0 : nval1) >= target;
    end
    check("wait_valid", 32'(got), 32'd1);
  endtask

  task automatic wait_cs0(input int budget);
    int n = 0;
    while (b0.o_cs_n && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wait_cs_low", 32'(b0.o_cs_n), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    vecs[0] = '{16'h0ABC, 21'h000ABC};
    vecs[1] = '{16'hFFFF, 21'h000FFF};
    vecs[2] = '{16'h0000, 21'h000000};
    vecs[3] = '{16'hF123, 21'h000123};
    vecs[4] = '{16'h0800, 21'h000800};
    vecs[5] = '{16'h5A5A, 21'h000A5A};
    vecs[6] = '{16'hA5A5, 21'h0005A5};
    vecs[7] = '{16'h0001, 21'h000001};

    rst = 1'b0;
    b0.i_enable = 1'b0;
    b1.i_enable = 1'b0;
    adc_word = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_pins", {28'd0, b0.o_cs_n, b0.o_sclk,
                         b0.o_valid, b0.o_overrun}, 32'hC);
    check("reset_data", 32'(b0.o_data), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      adc_word = vecs[i].frame;
      q0.push_back(vecs[i].exp);
      if (i == 0) begin
        b0.i_enable = 1'b1;
        t0 = cyc;
      end
      wait_v(0, i + 1, 500);
      if (i == 0) check("first_latency", 32'(lastv0 - t0), 32'd332);
      else        check("period", 32'(gap0), 32'd200);
      check("cs_low_width", 32'(cswid0), 32'd132);
      check("sclk_rises", 32'(nrise0), 32'd16);
    end

    // enable drops mid-frame: frame finishes, nothing follows
    adc_word = 16'h0123;
    q0.push_back(21'h000123);
    wait_cs0(400);
    repeat (20) @(negedge clk);
    b0.i_enable = 1'b0;
    wait_v(0, 9, 300);
    n = nval0;
    repeat (400) @(negedge clk);
    #1;
    check("no_frame_after_disable", 32'(nval0), 32'(n));
    check("cs_idle_after_disable", 32'(b0.o_cs_n), 32'd1);

    // reset at the eighth SCLK rise
    b0.i_enable = 1'b1;
    adc_word = 16'hFFFF;
    wait_cs0(400);
    n = 0;
    while (rises0 < 8 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reached_rise8", 32'(rises0), 32'd8);
    rst = 1'b0;
    #1;
    check("midreset_pins", {28'd0, b0.o_cs_n, b0.o_sclk,
                            b0.o_valid, b0.o_overrun}, 32'hC);
    check("midreset_data", 32'(b0.o_data), 32'd0);
    n = nval0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    adc_word = 16'h0555;
    q0.push_back(21'h000555);
    t0 = cyc;
    wait_v(0, n + 1, 500);
    check("post_reset_latency", 32'(lastv0 - t0), 32'd332);
    check("post_reset_cs_width", 32'(cswid0), 32'd132);
    b0.i_enable = 1'b0;

    // short conversion period: every other tick overruns
    adc_word = 16'h0C3C;
    q1.push_back(21'h000C3C);
    b1.i_enable = 1'b1;
    t0 = cyc;
    wait_v(1, 1, 400);
    check("ovr_first_latency", 32'(lastv1 - t0), 32'd232);
    adc_word = 16'h0F0F;
    q1.push_back(21'h000F0F);
    wait_v(1, 2, 400);
    check("ovr_period", 32'(gap1), 32'd200);
    adc_word = 16'h0246;
    q1.push_back(21'h000246);
    wait_v(1, 3, 400);
    check("ovr_period", 32'(gap1), 32'd200);
    b1.i_enable = 1'b0;

    check("sclk_high_when_idle", 32'(sclkbad), 32'd0);
    check("q0_drained", 32'(q0.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
